// File: rtl/picorv_axil_mem.sv
// picorv_axil_mem: AXI-lite slave word memory for the picorv32_axi master port.
// Latency: LATENCY cycles from AW+W (write) or AR (read) acceptance to bvalid/rvalid.
// Backpressure: one read and one write outstanding; each channel's readies stay low until its response handshake.
// Optional: define PICORV_AXIL_MEM_TOHOST_EN to add the tohost exit register at TOHOST_ADDR.
module picorv_axil_mem #(
  parameter int          MEM_WORDS   = 16384,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] TOHOST_ADDR = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_axi_awvalid,
  output logic        mem_axi_awready,
  input  logic [31:0] mem_axi_awaddr,
  input  logic [2:0]  mem_axi_awprot,
  input  logic        mem_axi_wvalid,
  output logic        mem_axi_wready,
  input  logic [31:0] mem_axi_wdata,
  input  logic [3:0]  mem_axi_wstrb,
  output logic        mem_axi_bvalid,
  input  logic        mem_axi_bready,
  input  logic        mem_axi_arvalid,
  output logic        mem_axi_arready,
  input  logic [31:0] mem_axi_araddr,
  input  logic [2:0]  mem_axi_arprot,
  output logic        mem_axi_rvalid,
  input  logic        mem_axi_rready,
`ifdef PICORV_AXIL_MEM_TOHOST_EN
  output logic        tohost_valid,
  output logic [31:0] tohost_data,
`endif
  output logic [31:0] mem_axi_rdata
);

  localparam int         AW       = $clog2(MEM_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_t;

  logic [31:0] mem [MEM_WORDS];

  wstate_t     wstate, wstate_nx;
  rstate_t     rstate, rstate_nx;
  logic        live;
  logic        aw_held, w_held;
  logic [31:0] awaddr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic [3:0]  wcnt, wcnt_nx, rcnt, rcnt_nx;
  logic        aw_fire, w_fire, ar_fire, commit;
  logic [31:0] cmt_addr, cmt_data;
  logic [3:0]  cmt_strb;
  logic        cmt_in_range, ar_in_range, cmt_tohost;

  // Handshakes are derived from state directly so they never loop through the ready outputs.
  assign aw_fire = mem_axi_awvalid & live & (wstate == W_IDLE) & ~aw_held;
  assign w_fire  = mem_axi_wvalid  & live & (wstate == W_IDLE) & ~w_held;
  assign ar_fire = mem_axi_arvalid & live & (rstate == R_IDLE);

  // The commit source is the holding register, or the bus itself when it is captured on the commit edge.
  assign cmt_addr     = aw_held ? awaddr_q : mem_axi_awaddr;
  assign cmt_data     = w_held  ? wdata_q  : mem_axi_wdata;
  assign cmt_strb     = w_held  ? wstrb_q  : mem_axi_wstrb;
  assign cmt_in_range = (cmt_addr[31:AW+2] == '0);
  assign ar_in_range  = (mem_axi_araddr[31:AW+2] == '0);

  // Write FSM: next state, commit strobe and handshake outputs.
  always_comb begin
    wstate_nx       = wstate;
    wcnt_nx         = wcnt;
    commit          = 1'b0;
    mem_axi_awready = 1'b0;
    mem_axi_wready  = 1'b0;
    mem_axi_bvalid  = 1'b0;
    case (wstate)
      W_IDLE: begin
        mem_axi_awready = live & ~aw_held;
        mem_axi_wready  = live & ~w_held;
        if ((aw_held | aw_fire) && (w_held | w_fire)) begin
          if (LATENCY == 1) begin
            commit    = 1'b1;
            wstate_nx = W_RESP;
          end else begin
            wstate_nx = W_WAIT;
            wcnt_nx   = CNT_INIT;
          end
        end
      end
      W_WAIT: begin
        // Commit on the edge where the down-counter reaches zero.
        if (wcnt == 4'd1) begin
          commit    = 1'b1;
          wstate_nx = W_RESP;
        end else begin
          wcnt_nx = wcnt - 4'd1;
        end
      end
      W_RESP: begin
        mem_axi_bvalid = 1'b1;
        if (mem_axi_bready) wstate_nx = W_IDLE;
      end
      default: wstate_nx = W_IDLE;
    endcase
  end

  // Read FSM: next state and handshake outputs.
  always_comb begin
    rstate_nx       = rstate;
    rcnt_nx         = rcnt;
    mem_axi_arready = 1'b0;
    mem_axi_rvalid  = 1'b0;
    case (rstate)
      R_IDLE: begin
        mem_axi_arready = live;
        if (ar_fire) begin
          if (LATENCY == 1) begin
            rstate_nx = R_RESP;
          end else begin
            rstate_nx = R_WAIT;
            rcnt_nx   = CNT_INIT;
          end
        end
      end
      R_WAIT: begin
        if (rcnt == 4'd1) rstate_nx = R_RESP;
        else rcnt_nx = rcnt - 4'd1;
      end
      R_RESP: begin
        mem_axi_rvalid = 1'b1;
        if (mem_axi_rready) rstate_nx = R_IDLE;
      end
      default: rstate_nx = R_IDLE;
    endcase
  end

  // State, counters and write holding registers; live keeps readies low until the cycle after reset release.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      live     <= 1'b0;
      wstate   <= W_IDLE;
      rstate   <= R_IDLE;
      wcnt     <= '0;
      rcnt     <= '0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      live   <= 1'b1;
      wstate <= wstate_nx;
      rstate <= rstate_nx;
      wcnt   <= wcnt_nx;
      rcnt   <= rcnt_nx;
      if (aw_fire) begin
        aw_held  <= 1'b1;
        awaddr_q <= mem_axi_awaddr;
      end
      if (w_fire) begin
        w_held  <= 1'b1;
        wdata_q <= mem_axi_wdata;
        wstrb_q <= mem_axi_wstrb;
      end
      if (wstate == W_RESP && mem_axi_bready) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  // Read data register: sampled at AR acceptance, so a same-edge commit is not visible.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_axi_rdata <= '0;
    end else if (ar_fire) begin
      mem_axi_rdata <= ar_in_range ? mem[mem_axi_araddr[AW+1:2]] : 32'hDEAD_BEEF;
    end
  end

  // Byte-masked memory write; contents survive reset and an interrupted transaction never lands.
  always_ff @(posedge clk) begin
    if (resetn && commit && cmt_in_range && !cmt_tohost) begin
      for (int b = 0; b < 4; b++) begin
        if (cmt_strb[b]) mem[cmt_addr[AW+1:2]][8*b +: 8] <= cmt_data[8*b +: 8];
      end
    end
  end

`ifdef PICORV_AXIL_MEM_TOHOST_EN
  assign cmt_tohost = (cmt_addr == TOHOST_ADDR);

  // Exit register: one-cycle pulse with the written word, aligned with bvalid rising.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tohost_valid <= 1'b0;
      tohost_data  <= '0;
    end else begin
      tohost_valid <= commit & cmt_tohost;
      if (commit && cmt_tohost) tohost_data <= cmt_data;
    end
  end

  logic unused_sig;
  assign unused_sig = ^{mem_axi_awprot, mem_axi_arprot, mem_axi_araddr[1:0]};
`else
  assign cmt_tohost = 1'b0;

  logic unused_sig;
  assign unused_sig = ^{mem_axi_awprot, mem_axi_arprot, mem_axi_araddr[1:0], cmt_addr[1:0], TOHOST_ADDR};
`endif

endmodule

// File: doc/picorv_axil_mem.md
PICORV_AXIL_MEM -- requirements
Module: picorv_axil_mem

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 16384, giving memory depth in 32-bit words (power of 2).
REQ-002 SHALL have parameter LATENCY, default 1, legal range 1..15: cycles from command acceptance to response valid.
REQ-003 SHALL have parameter TOHOST_ADDR, default 32'h1000_0000: byte address of the test-exit register.
REQ-004 SHALL have these ports, all AXI-lite slave signals matching the picorv32_axi master port one-to-one:
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- mem_axi_awvalid/awready  in/out  1  write-address handshake.
- mem_axi_awaddr  in  32  write byte address.
- mem_axi_awprot  in  3  ignored.
- mem_axi_wvalid/wready  in/out  1  write-data handshake.
- mem_axi_wdata  in  32  write data.
- mem_axi_wstrb  in  4  byte enables.
- mem_axi_bvalid/bready  out/in  1  write response.
- mem_axi_arvalid/arready  in/out  1  read-address handshake.
- mem_axi_araddr  in  32  read byte address.
- mem_axi_arprot  in  3  ignored.
- mem_axi_rvalid/rready  out/in  1  read response.
- mem_axi_rdata  out  32  read data.

Function
REQ-005 Word index SHALL be addr[log2(MEM_WORDS)+1:2]; addr[1:0] SHALL be ignored; an address is in range iff addr < 4*MEM_WORDS.
REQ-006 Write FSM states: W_IDLE, W_WAIT, W_RESP.
REQ-007 In W_IDLE, awready SHALL be 1 until AW is captured and wready SHALL be 1 until W is captured; AW and W SHALL be accepted in either order or in the same cycle, each into its own holding register.
REQ-008 Once both are held, the FSM SHALL go to W_WAIT, load a down-counter with LATENCY-1, and commit the write when the counter reaches 0, updating only the bytes with wstrb set; it SHALL then enter W_RESP with bvalid=1.
REQ-009 With LATENCY=1, bvalid SHALL rise in the cycle after the second of the two handshakes completes.
REQ-010 In W_RESP, bvalid SHALL hold until bready=1, then return to W_IDLE; awready and wready SHALL be 0 from capture until this return.
REQ-011 An out-of-range write SHALL leave memory unchanged and still produce bvalid.
REQ-012 Read FSM states: R_IDLE, R_WAIT, R_RESP.
REQ-013 arready SHALL be 1 only in R_IDLE. On arvalid&arready the FSM SHALL sample the memory word into the rdata register in that cycle and count LATENCY-1 cycles in R_WAIT.
REQ-014 In R_RESP, rvalid SHALL be 1 and rdata SHALL be stable until rready=1, then the FSM SHALL return to R_IDLE.
REQ-015 An out-of-range read SHALL return 32'hDEAD_BEEF.
REQ-016 Read and write channels SHALL operate independently; a read sampled in the same cycle as a write commit to the same word SHALL return the pre-write value.
REQ-017 The block SHALL never assert awready, wready or arready while the corresponding response is pending, so at most one read and one write are outstanding.

Reset
REQ-018 While resetn=0, all FSMs SHALL be idle, holding registers and counters SHALL be cleared, and awready, wready, arready, bvalid, rvalid and rdata SHALL be 0.
REQ-019 The ready outputs SHALL first be 1 in the first cycle after resetn is sampled 1.
REQ-020 Reset asserted mid-transaction SHALL discard that transaction with no memory write; memory contents SHALL NOT be reset.

Configuration
REQ-021 With macro PICORV_AXIL_MEM_TOHOST_EN defined:
- the block SHALL add outputs tohost_valid (1 bit) and tohost_data (32 bits), both reset to 0;
- a write to TOHOST_ADDR SHALL not modify memory;
- at that write's commit, tohost_data SHALL load wdata and tohost_valid SHALL pulse 1 for one cycle;
- bvalid SHALL still be returned.
REQ-022 Without the macro, these ports SHALL be absent and TOHOST_ADDR SHALL be an ordinary (normally out-of-range) address.

Verification
REQ-023 LATENCY=1: AW 0x10 and W 0xA5A5_1234 with wstrb 4'hF in the same cycle, bready=1 -> bvalid 1 cycle later; read of 0x10 -> rvalid 1 cycle after AR with rdata 0xA5A5_1234.
REQ-024 W presented 3 cycles before AW (0x20, wstrb 4'b0101, data 0x1122_3344 over 0) -> wready drops after W capture; word 0x20 reads 0x0022_0044.
REQ-025 LATENCY=4, bready and rready held 0 for 5 cycles -> bvalid/rvalid stay 1 with stable rdata; awready and arready stay 0 until each response handshake completes.
REQ-026 Read of 0x0010_0000 with MEM_WORDS=16384 -> rdata 0xDEAD_BEEF; write to the same address -> bvalid returned, memory unchanged.
REQ-027 resetn=0 during W_WAIT of a write to 0x40 -> after reset, 0x40 holds its old value, bvalid=0, awready=1 one cycle after release.
REQ-028 PICORV_AXIL_MEM_TOHOST_EN defined, write 0x1 to 0x1000_0000 -> one-cycle tohost_valid with tohost_data 0x1, bvalid asserted.
